// File: rtl/pio_tx_pkg.sv
// pio_tx_pkg: state type and width helpers for the bidirectional pad transmitter
package pio_tx_pkg;
  typedef enum logic [2:0] {IDLE, TURN_ON, SHIFT, HOLD, TURN_OFF} pio_tx_state_e;
  function automatic int pio_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int pio_max(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/pio_bit_timer.sv
// pio_bit_timer: wrapping 0..i_max counter with a terminal-count pulse and a one-cycle lookahead of it
module pio_bit_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_max,
  output logic         o_tc,
  output logic         o_tc_nxt
);
  logic [W-1:0] r_cnt, w_cnt_n;
  assign w_cnt_n  = i_clr ? '0 : (i_en ? (r_cnt == i_max ? '0 : r_cnt + 1'b1) : r_cnt);
  assign o_tc     = i_en && r_cnt == i_max;
  assign o_tc_nxt = w_cnt_n == i_max;
  always_ff @(posedge clk) r_cnt <= rst ? '0 : w_cnt_n;
endmodule

// File: rtl/pio_bidir_tx.sv
// pio_bidir_tx: serialises a valid/ready word stream onto one bidirectional pad with driven turnaround
module pio_bidir_tx
  import pio_tx_pkg::*;
#(
  parameter int   DATA_W     = 8,
  parameter int   CLK_DIV    = 1,
  parameter int   TURN_CYC   = 2,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              pad_o,
  output logic              pad_t,
  output logic              busy,
  output logic              done
);
  localparam int BW = pio_w(DATA_W);
  localparam int TW = pio_max(pio_w(CLK_DIV), pio_w(TURN_CYC + 1));
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
  pio_tx_state_e     r_state, w_state_n;
  logic [DATA_W-1:0] r_sh, w_sh_n;
  logic [BW-1:0]     r_bit, w_bit_n;
  logic              r_last, w_last_n;
  logic              r_s_ready, r_pad_o, r_pad_t, r_busy, r_done;
  logic              w_acc, w_timing, w_shift, w_tc, w_tc_nxt, w_final_n;
  logic [TW-1:0]     w_max;
  assign w_acc    = s_valid && r_s_ready;
  assign w_shift  = r_state == SHIFT;
  assign w_timing = r_state inside {TURN_ON, SHIFT, TURN_OFF};
  assign w_max    = w_shift ? TW'(CLK_DIV - 1) : TW'(TURN_CYC - 1);
  // one counter times both bit periods and turnarounds; it wraps to 0 on every state hand-off
  pio_bit_timer #(.W(TW)) u_timer (
    .clk(clk), .rst(rst), .i_clr(!w_timing), .i_en(w_timing), .i_max(w_max),
    .o_tc(w_tc), .o_tc_nxt(w_tc_nxt)
  );
  always_comb begin
    w_state_n = r_state;
    w_sh_n    = w_acc ? s_data : (w_shift && w_tc ? r_sh << 1 : r_sh);
    w_last_n  = w_acc ? s_last : r_last;
    w_bit_n   = !w_shift ? '0 : (!w_tc ? r_bit : (r_bit == BIT_LAST ? '0 : r_bit + 1'b1));
    case (r_state)
      IDLE:     w_state_n = w_acc ? (TURN_CYC == 0 ? SHIFT : TURN_ON) : IDLE;
      TURN_ON:  w_state_n = w_tc ? SHIFT : TURN_ON;
      SHIFT:    if (w_tc && r_bit == BIT_LAST)
                  w_state_n = r_last ? (TURN_CYC == 0 ? IDLE : TURN_OFF) : (w_acc ? SHIFT : HOLD);
      HOLD:     w_state_n = w_acc ? SHIFT : HOLD;
      TURN_OFF: w_state_n = w_tc ? IDLE : TURN_OFF;
      default:  w_state_n = IDLE;
    endcase
  end
  // next cycle is the last cycle of the last bit; a freshly entered SHIFT always starts at count 0
  assign w_final_n = w_bit_n == BIT_LAST && (w_shift ? w_tc_nxt : CLK_DIV == 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_sh      <= '0;
      r_bit     <= '0;
      r_last    <= 1'b0;
      r_s_ready <= 1'b0;
      r_pad_o   <= IDLE_LEVEL;
      r_pad_t   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_sh      <= w_sh_n;
      r_bit     <= w_bit_n;
      r_last    <= w_last_n;
      r_s_ready <= w_state_n inside {IDLE, HOLD} || (w_state_n == SHIFT && !w_last_n && w_final_n);
      r_pad_o   <= w_state_n == SHIFT ? w_sh_n[DATA_W-1] : IDLE_LEVEL;
      r_pad_t   <= w_state_n == IDLE;
      r_busy    <= w_state_n != IDLE;
      r_done    <= w_state_n == IDLE && r_state != IDLE;
    end
  end
  assign s_ready = r_s_ready;
  assign pad_o   = r_pad_o;
  assign pad_t   = r_pad_t;
  assign busy    = r_busy;
  assign done    = r_done;
endmodule

// File: tb/tb_pio_bidir_tx.sv
// tb_pio_bidir_tx: four pad transmitters share one random stimulus; a queue-based pad schedule predicts each
module tb_pio_bidir_tx;
  localparam int NC = 4;
  localparam int DWS  [NC] = '{8, 8, 1, 5};
  localparam int DIVS [NC] = '{1, 3, 1, 2};
  localparam int TCS  [NC] = '{2, 2, 0, 1};
  localparam int ILS  [NC] = '{1, 1, 1, 0};
  typedef struct packed {logic t; logic o; logic rdy; logic busy; logic done;} exp_t;
  logic clk, rst, s_valid, s_last;
  logic [7:0] s_data;
  logic s_ready [NC];
  logic pad_o [NC];
  logic pad_t [NC];
  logic busy [NC];
  logic done [NC];
  logic sched [NC][$];
  exp_t exp_q [NC][$];
  logic open_b [NC];
  logic cur_rdy [NC];
  int n_cmp = 0, n_bad = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < NC; g++) begin : cfg
    pio_bidir_tx #(.DATA_W(DWS[g]), .CLK_DIV(DIVS[g]), .TURN_CYC(TCS[g]), .IDLE_LEVEL(ILS[g] != 0)) u_dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data[DWS[g]-1:0]), .s_last(s_last),
      .s_ready(s_ready[g]), .pad_o(pad_o[g]), .pad_t(pad_t[g]), .busy(busy[g]), .done(done[g])
    );
  end
  // reference: every accepted word appends its future pad cycles to a schedule; an empty schedule is hold or release
  initial begin
    for (int k = 0; k < NC; k++) begin
      open_b[k] = 1'b0;
      cur_rdy[k] = 1'b0;
    end
    forever begin
      @(posedge clk);
      for (int k = 0; k < NC; k++) begin
        exp_t e;
        logic popped, acc, il, tmp;
        il = ILS[k] != 0;
        popped = 1'b0;
        if (rst) begin
          sched[k].delete();
          open_b[k] = 1'b0;
          e = {1'b1, il, 3'b000};
        end else begin
          if (sched[k].size() > 0) begin
            tmp = sched[k].pop_front();
            popped = 1'b1;
          end
          acc = s_valid && cur_rdy[k];
          if (acc) begin
            if (!open_b[k]) repeat (TCS[k]) sched[k].push_back(il);
            for (int i = DWS[k] - 1; i >= 0; i--) repeat (DIVS[k]) sched[k].push_back(s_data[i]);
            if (s_last) repeat (TCS[k]) sched[k].push_back(il);
            open_b[k] = !s_last;
          end
          e.t    = sched[k].size() == 0 && !open_b[k];
          e.o    = sched[k].size() == 0 ? il : sched[k][0];
          e.rdy  = sched[k].size() == 0 || (open_b[k] && sched[k].size() == 1);
          e.busy = !e.t;
          e.done = popped && e.t;
        end
        cur_rdy[k] = e.rdy;
        exp_q[k].push_back(e);
      end
    end
  end
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < NC; k++) begin
      exp_t e, act;
      n_cmp++;
      if (exp_q[k].size() == 0) begin
        n_bad++;
        $display("FAIL cfg%0d t=%0t no expectation queued", k, $time);
      end else begin
        e = exp_q[k].pop_front();
        act = {pad_t[k], pad_o[k], s_ready[k], busy[k], done[k]};
        if (act !== e) begin
          n_bad++;
          $display("FAIL cfg%0d t=%0t {pad_t,pad_o,s_ready,busy,done} got %b expected %b", k, $time, act, e);
        end
      end
    end
  end
  task automatic cyc(input logic v, input logic [7:0] d, input logic l);
    s_valid = v;
    s_data = d;
    s_last = l;
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 8'($urandom), 1'($urandom));
  endtask
  initial begin
    rst = 1'b1;
    s_valid = 1'b1;
    s_data = 8'h3C;
    s_last = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    idle(3);
    cyc(1'b1, 8'hA5, 1'b1);
    idle(40);
    cyc(1'b1, 8'h81, 1'b0);
    repeat (30) cyc(1'b1, 8'h7E, 1'b1);
    idle(40);
    cyc(1'b1, 8'h81, 1'b0);
    idle(30);
    cyc(1'b1, 8'h7E, 1'b1);
    idle(40);
    cyc(1'b1, 8'hFF, 1'b1);
    idle(5);
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(5);
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        idle($urandom_range(1, 3));
        rst = 1'b0;
      end
      cyc($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 5) == 0);
    end
    idle(60);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
